dmem_router: RTL and testbench

DMEM_ROUTER -- requirements
Module: dmem_router

---
 rtl/dmem_router.sv | 212 +++++++++++++++++++++
 tb/tb_dmem_router.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_router.sv
// Data-memory router: one master write/read port fanned out to NSLV slaves by address[31:28].
// Define DMEM_ROUTER_ERR_EN to turn unmapped accesses into error responses instead of routing them to slave 0.

// One slave lane: address match and the lowest-index-wins priority ripple.
module dmem_router_lane #(
    parameter logic [3:0] BASE = 4'h0
) (
    input  logic [3:0] wnib,
    input  logic [3:0] rnib,
    input  logic       wtaken_in,
    input  logic       rtaken_in,
    input  logic       wfallback,
    input  logic       rfallback,
    input  logic       wreq,
    input  logic       rreq,
    output logic       wtaken_out,
    output logic       rtaken_out,
    output logic       whit,
    output logic       rhit,
    output logic       s_wready,
    output logic       s_rready
);
    logic wmatch;
    logic rmatch;

    assign wmatch     = (wnib == BASE);
    assign rmatch     = (rnib == BASE);
    assign wtaken_out = wtaken_in | wmatch;
    assign rtaken_out = rtaken_in | rmatch;
    assign whit       = (wmatch && !wtaken_in) || wfallback;
    assign rhit       = (rmatch && !rtaken_in) || rfallback;
    assign s_wready   = wreq && whit;
    assign s_rready   = rreq && rhit;
endmodule

module dmem_router #(
    parameter int                   NSLV     = 2,
    parameter int                   RD_DEPTH = 2,
    parameter logic [4*NSLV-1:0]    SLV_BASE = 8'h80
) (
    input  logic                 clk,
    input  logic                 reset,
    // master write
    input  logic                 m_wready,
    output logic                 m_wvalid,
    input  logic [31:0]          m_waddr,
    input  logic [31:0]          m_wdata,
    input  logic [3:0]           m_wstrb,
    // master read
    input  logic                 m_rready,
    output logic                 m_rvalid,
    input  logic [31:0]          m_raddr,
    output logic                 m_rresp,
    output logic [31:0]          m_rdata,
    // slave write
    output logic [NSLV-1:0]      s_wready,
    input  logic [NSLV-1:0]      s_wvalid,
    output logic [31:0]          s_waddr,
    output logic [31:0]          s_wdata,
    output logic [3:0]           s_wstrb,
    // slave read
    output logic [NSLV-1:0]      s_rready,
    input  logic [NSLV-1:0]      s_rvalid,
    output logic [31:0]          s_raddr,
    input  logic [NSLV-1:0]      s_rresp,
    input  logic [NSLV*32-1:0]   s_rdata,
    output logic [NSLV-1:0]      s_rack,
    output logic                 err
);
`ifdef DMEM_ROUTER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int PW = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
    localparam int CW = $clog2(RD_DEPTH + 1);

    typedef struct packed {
        logic          err;
        logic [IW-1:0] idx;
    } tag_t;

    logic [NSLV:0]   wtaken;
    logic [NSLV:0]   rtaken;
    logic [NSLV-1:0] whit;
    logic [NSLV-1:0] rhit;
    logic            wmiss;
    logic            rmiss;
    logic            rd_open;
    logic            rd_req;
    logic [IW-1:0]   ridx;

    logic [CW-1:0]   count;
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    tag_t            mem [RD_DEPTH];
    tag_t            head;
    tag_t            push_tag;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            rd_err;
    logic            wr_err_q;

    assign wtaken[0] = 1'b0;
    assign rtaken[0] = 1'b0;
    assign wmiss     = !wtaken[NSLV];
    assign rmiss     = !rtaken[NSLV];

    // Full blocks acceptance even when a pop lands in the same cycle.
    assign fifo_full  = (count == CW'(RD_DEPTH));
    assign fifo_empty = (count == '0);
    assign rd_open    = !fifo_full && !reset;
    assign rd_req     = m_rready && rd_open;

    genvar gi;
    generate
        for (gi = 0; gi < NSLV; gi++) begin : g_lane
            logic wfb;
            logic rfb;
            // Without the error feature, unmapped traffic falls through to slave 0.
            if (gi == 0) begin : g_fb
                assign wfb = !ERR_EN && wmiss;
                assign rfb = !ERR_EN && rmiss;
            end else begin : g_nofb
                assign wfb = 1'b0;
                assign rfb = 1'b0;
            end

            dmem_router_lane #(
                .BASE (SLV_BASE[4*gi +: 4])
            ) u_lane (
                .wnib       (m_waddr[31:28]),
                .rnib       (m_raddr[31:28]),
                .wtaken_in  (wtaken[gi]),
                .rtaken_in  (rtaken[gi]),
                .wfallback  (wfb),
                .rfallback  (rfb),
                .wreq       (m_wready),
                .rreq       (rd_req),
                .wtaken_out (wtaken[gi+1]),
                .rtaken_out (rtaken[gi+1]),
                .whit       (whit[gi]),
                .rhit       (rhit[gi]),
                .s_wready   (s_wready[gi]),
                .s_rready   (s_rready[gi])
            );
        end
    endgenerate

    assign s_waddr  = m_waddr;
    assign s_wdata  = m_wdata;
    assign s_wstrb  = m_wstrb;
    assign s_raddr  = m_raddr;

    // Unmapped writes (error build) are swallowed immediately.
    assign m_wvalid = |(s_wvalid & whit) || (ERR_EN && wmiss);
    assign m_rvalid = rd_open && (|(s_rvalid & rhit) || (ERR_EN && rmiss));

    always_comb begin
        ridx = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (rhit[i]) ridx = IW'(i);
        end
    end

    assign push         = m_rready && m_rvalid;
    assign push_tag.err = ERR_EN && rmiss;
    assign push_tag.idx = ridx;
    assign head         = mem[rptr];

    always_comb begin
        m_rresp = 1'b0;
        m_rdata = 32'h0;
        s_rack  = '0;
        rd_err  = 1'b0;
        if (!fifo_empty) begin
            if (head.err) begin
                m_rresp = 1'b1;
                rd_err  = 1'b1;
            end else begin
                m_rresp          = s_rresp[head.idx];
                m_rdata          = s_rdata[head.idx*32 +: 32];
                s_rack[head.idx] = s_rresp[head.idx];
            end
        end
    end

    assign pop = m_rresp;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_tag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            if (push) wptr <= PW'((32'(wptr) + 1) % RD_DEPTH);
            if (pop)  rptr <= PW'((32'(rptr) + 1) % RD_DEPTH);
            count    <= count + CW'(push) - CW'(pop);
            wr_err_q <= ERR_EN && wmiss && m_wready;
        end
    end

    assign err = wr_err_q || rd_err;
endmodule

// File: tb/tb_dmem_router.sv
// Directed bench for dmem_router (default build): write routing, in-order read returns, FIFO full, reset flush.
module tb_dmem_router;
    logic        clk = 1'b0;
    logic        reset;
    logic        m_wready, m_wvalid;
    logic [31:0] m_waddr, m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_rready, m_rvalid, m_rresp;
    logic [31:0] m_raddr, m_rdata;
    logic [1:0]  s_wready, s_wvalid, s_rready, s_rvalid, s_rresp, s_rack;
    logic [31:0] s_waddr, s_wdata, s_raddr;
    logic [3:0]  s_wstrb;
    logic [63:0] s_rdata;
    logic        err;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_router #(.NSLV(2), .RD_DEPTH(2), .SLV_BASE(8'h80)) dut (
        .clk(clk), .reset(reset),
        .m_wready(m_wready), .m_wvalid(m_wvalid), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rready(m_rready), .m_rvalid(m_rvalid), .m_raddr(m_raddr), .m_rresp(m_rresp), .m_rdata(m_rdata),
        .s_wready(s_wready), .s_wvalid(s_wvalid), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rready(s_rready), .s_rvalid(s_rvalid), .s_raddr(s_raddr), .s_rresp(s_rresp), .s_rdata(s_rdata),
        .s_rack(s_rack), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Read accepted this cycle: expect acceptance and queue the data the slave will later return.
    task automatic expect_accept(input string tag, input int idx, input logic [31:0] data);
        logic [1:0] onehot;
        onehot = 2'b01 << idx;
        check({tag, "_rvalid"}, {31'b0, m_rvalid}, 32'd1);
        check({tag, "_rready"}, {30'b0, s_rready}, {30'b0, onehot});
        sb.push_back('{idx, data});
    endtask

    task automatic expect_resp(input string tag);
        exp_t e;
        logic [1:0] onehot;
        if (sb.size() == 0) begin
            check({tag, "_sb_underflow"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            onehot = 2'b01 << e.idx;
            check({tag, "_rresp"}, {31'b0, m_rresp}, 32'd1);
            check({tag, "_rdata"}, m_rdata, e.data);
            check({tag, "_rack"}, {30'b0, s_rack}, {30'b0, onehot});
        end
    endtask

    initial begin
        reset = 1'b1;
        m_wready = 0; m_waddr = 0; m_wdata = 0; m_wstrb = 0;
        m_rready = 0; m_raddr = 0;
        s_wvalid = 0; s_rvalid = 0; s_rresp = 0; s_rdata = '0;
        step(); step();

        // No acceptance while reset is high
        m_rready = 1; s_rvalid = 2'b11;
        settle();
        check("rst_rvalid", {31'b0, m_rvalid}, 32'd0);
        check("rst_rready", {30'b0, s_rready}, 32'd0);
        step();
        reset = 0; m_rready = 0; s_rvalid = 0;
        settle();
        check("rst_rresp", {31'b0, m_rresp}, 32'd0);
        check("rst_rack", {30'b0, s_rack}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);

        // Write to slave 1
        m_wready = 1; m_waddr = 32'h8000_0010; m_wdata = 32'hDEAD_BEEF; m_wstrb = 4'hA; s_wvalid = 2'b10;
        settle();
        check("w1_wready", {30'b0, s_wready}, 32'h2);
        check("w1_wvalid", {31'b0, m_wvalid}, 32'd1);
        check("w1_wdata", s_wdata, 32'hDEAD_BEEF);
        check("w1_waddr", s_waddr, 32'h8000_0010);
        check("w1_wstrb", {28'b0, s_wstrb}, 32'hA);
        s_wvalid = 2'b01;
        settle();
        check("w1_wvalid_s0only", {31'b0, m_wvalid}, 32'd0);

        // Unmapped write falls to slave 0, no error
        m_waddr = 32'h4000_0000;
        settle();
        check("wun_wready", {30'b0, s_wready}, 32'h1);
        check("wun_wvalid", {31'b0, m_wvalid}, 32'd1);
        step();
        check("wun_err", {31'b0, err}, 32'd0);
        m_wready = 0; s_wvalid = 0;

        // Two reads, slave 1 answers first but slave 0 data must come back first
        m_rready = 1; m_raddr = 32'h0000_0000; s_rvalid = 2'b11;
        settle();
        expect_accept("rd0", 0, 32'hA000_0001);
        step();
        m_raddr = 32'h8000_0000;
        settle();
        expect_accept("rd1", 1, 32'hB000_0001);
        step();
        m_rready = 0; s_rresp = 2'b10; s_rdata[63:32] = 32'hB000_0001;
        settle();
        check("ooo_rresp", {31'b0, m_rresp}, 32'd0);
        check("ooo_rack", {30'b0, s_rack}, 32'd0);
        step();
        s_rresp = 2'b11; s_rdata[31:0] = 32'hA000_0001;
        settle();
        expect_resp("resp0");
        step();
        s_rresp = 2'b10;
        settle();
        expect_resp("resp1");
        step();
        s_rresp = 2'b00;
        settle();
        check("empty_rresp", {31'b0, m_rresp}, 32'd0);
        check("empty_rdata", m_rdata, 32'h0);

        // Fill the FIFO, third read blocked until a pop has taken effect
        m_rready = 1; m_raddr = 32'h0000_0000;
        settle();
        expect_accept("f0", 0, 32'hA000_0002);
        step();
        m_raddr = 32'h8000_0000;
        settle();
        expect_accept("f1", 1, 32'hB000_0002);
        step();
        m_raddr = 32'h0000_0000;
        settle();
        check("full_rvalid", {31'b0, m_rvalid}, 32'd0);
        check("full_rready", {30'b0, s_rready}, 32'd0);
        step();
        s_rresp = 2'b01; s_rdata[31:0] = 32'hA000_0002;
        settle();
        check("full_pop_rvalid", {31'b0, m_rvalid}, 32'd0);
        expect_resp("fresp0");
        step();
        s_rresp = 2'b00;
        settle();
        expect_accept("f2", 0, 32'hA000_0003);
        step();
        m_rready = 0; s_rresp = 2'b10; s_rdata[63:32] = 32'hB000_0002;
        settle();
        expect_resp("fresp1");
        step();
        s_rresp = 2'b01; s_rdata[31:0] = 32'hA000_0003;
        settle();
        expect_resp("fresp2");
        step();
        s_rresp = 2'b00;
        settle();
        check("f_empty_rresp", {31'b0, m_rresp}, 32'd0);

        // Push and pop in the same cycle
        m_rready = 1; m_raddr = 32'h0000_0000;
        settle();
        expect_accept("pp0", 0, 32'hA000_0004);
        step();
        m_raddr = 32'h8000_0000; s_rresp = 2'b01; s_rdata[31:0] = 32'hA000_0004;
        settle();
        expect_accept("pp1", 1, 32'hB000_0004);
        expect_resp("ppresp0");
        step();
        m_rready = 0; s_rresp = 2'b10; s_rdata[63:32] = 32'hB000_0004;
        settle();
        expect_resp("ppresp1");
        step();
        s_rresp = 2'b00;
        settle();
        check("pp_empty_rresp", {31'b0, m_rresp}, 32'd0);

        // Reset with two reads outstanding discards their tags
        m_rready = 1; m_raddr = 32'h0000_0000;
        settle();
        check("rr0_rvalid", {31'b0, m_rvalid}, 32'd1);
        step();
        m_raddr = 32'h8000_0000;
        settle();
        check("rr1_rvalid", {31'b0, m_rvalid}, 32'd1);
        step();
        m_rready = 0; reset = 1; s_rresp = 2'b11;
        step();
        reset = 0;
        settle();
        check("rr_rresp", {31'b0, m_rresp}, 32'd0);
        check("rr_rack", {30'b0, s_rack}, 32'd0);
        check("rr_err", {31'b0, err}, 32'd0);
        m_rready = 1; m_raddr = 32'h0000_0000;
        settle();
        check("rr_accept_after", {31'b0, m_rvalid}, 32'd1);
        step();
        m_rready = 0; s_rresp = 2'b00;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
